// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: data/byte-enable
// widths and the sequencer state codes.
package sdram_arb_pkg;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    // Sequencer states, kept as plain constants so older tools that
    // choke on enum typedefs can still consume this package.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_RD = 3'd2;
    localparam logic [2:0] ST_ACK     = 3'd3;
    localparam logic [2:0] ST_REFRESH = 3'd4;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh scheduler: a down-counter that raises a sticky
// pending flag on every expiry and flags an overrun when the previous
// refresh was still waiting to be serviced.
module sdram_refresh_timer #(
    parameter int REF_INTERVAL = 312
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic ref_pending_o,
    output logic ref_overrun_o
);

    localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    // Next-state: an expiry always re-arms pending, so it wins over a
    // clear arriving in the same cycle.
    always_comb begin
        expire    = (cnt_q == '0);
        cnt_d     = expire ? RELOAD : (cnt_q - CNT_W'(1));
        pending_d = expire | (pending_q & ~clear_i);
        overrun_d = expire & pending_q & ~clear_i;
    end

    // Timer registers; reset restarts a full interval with nothing pending.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign ref_pending_o = pending_q;
    assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Two-master round-robin arbiter and single-outstanding command sequencer
// in front of the SDRAM controller, with periodic refresh taking
// priority over new grants.
import sdram_arb_pkg::*;

module sdram_req_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int REF_INTERVAL = 312
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [SEL_W-1:0]  m0_sel,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [SEL_W-1:0]  m1_sel,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              c_valid,
    input  logic              c_ready,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wdata,
    output logic [SEL_W-1:0]  c_sel,
    input  logic              c_rvalid,
    input  logic [DATA_W-1:0] c_rdata,
    output logic              c_ref_req,
    input  logic              c_ref_ack,
    output logic              ref_overrun,
    output logic              grant
);

    logic [2:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              rr_q, rr_d;
    logic              c_we_q, c_we_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
    logic [SEL_W-1:0]  c_sel_q, c_sel_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              pick;
    logic              ref_pending;
    logic              ref_clear;

    assign ref_clear = (state_q == ST_REFRESH) && c_ref_ack;

    sdram_refresh_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_refresh_timer (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .clear_i      (ref_clear),
        .ref_pending_o(ref_pending),
        .ref_overrun_o(ref_overrun)
    );

    // Sequencer next-state: refresh beats new grants in IDLE, a lone
    // requester wins outright, and two requesters are split by rr_q.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        c_we_d     = c_we_q;
        c_addr_d   = c_addr_q;
        c_wdata_d  = c_wdata_q;
        c_sel_d    = c_sel_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        pick       = (m0_req && m1_req) ? rr_q : m1_req;
        case (state_q)
            ST_IDLE: begin
                if (ref_pending) begin
                    state_d = ST_REFRESH;
                end else if (m0_req || m1_req) begin
                    grant_d   = pick;
                    c_we_d    = pick ? m1_we    : m0_we;
                    c_addr_d  = pick ? m1_addr  : m0_addr;
                    c_wdata_d = pick ? m1_wdata : m0_wdata;
                    c_sel_d   = pick ? m1_sel   : m0_sel;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (c_ready) begin
                    state_d = c_we_q ? ST_ACK : ST_WAIT_RD;
                end
            end
            ST_WAIT_RD: begin
                if (c_rvalid) begin
                    if (grant_q) begin
                        m1_rdata_d = c_rdata;
                    end else begin
                        m0_rdata_d = c_rdata;
                    end
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                rr_d    = ~grant_q;
                state_d = ST_IDLE;
            end
            ST_REFRESH: begin
                if (c_ref_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset drops any in-flight command without an
    // ack and points the round-robin at m0.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            rr_q       <= 1'b0;
            c_we_q     <= 1'b0;
            c_addr_q   <= '0;
            c_wdata_q  <= '0;
            c_sel_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            c_we_q     <= c_we_d;
            c_addr_q   <= c_addr_d;
            c_wdata_q  <= c_wdata_d;
            c_sel_q    <= c_sel_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign c_valid   = (state_q == ST_ISSUE);
    assign c_ref_req = (state_q == ST_REFRESH);
    assign m0_ack    = (state_q == ST_ACK) && !grant_q;
    assign m1_ack    = (state_q == ST_ACK) && grant_q;
    assign c_we      = c_we_q;
    assign c_addr    = c_addr_q;
    assign c_wdata   = c_wdata_q;
    assign c_sel     = c_sel_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Self-checking bench for sdram_req_arbiter: directed transactions plus
// randomized masters/controller compared every cycle against a
// behavioural transaction model.
module tb_sdram_req_arbiter;

    localparam int AW = 23;
    localparam int RI = 64;

    localparam int P_IDLE    = 0;
    localparam int P_ISSUE   = 1;
    localparam int P_WAIT_RD = 2;
    localparam int P_ACK     = 3;
    localparam int P_REFRESH = 4;

    logic          clk;
    logic          rst;
    logic          req   [2];
    logic          we    [2];
    logic [AW-1:0] addr  [2];
    logic [31:0]   wdata [2];
    logic [3:0]    sel   [2];
    logic          ack0, ack1;
    logic [31:0]   rdata0, rdata1;
    logic          c_valid, c_ready, c_we, c_rvalid, c_ref_req, c_ref_ack;
    logic [AW-1:0] c_addr;
    logic [31:0]   c_wdata, c_rdata;
    logic [3:0]    c_sel;
    logic          ref_overrun, grant;

    int checks;
    int errors;

    int          mPhase, mCyc, mWho, mFav;
    bit          mPend, mOver;
    logic        mWe;
    logic [AW-1:0] mAddr;
    logic [31:0] mWdata;
    logic [3:0]  mSel;
    logic [31:0] mRd [2];

    int reqPct, wePct, readyPct, rvalidPct, refAckPct;
    bit altCheck;
    int lastAcked;

    sdram_req_arbiter #(
        .ADDR_W(AW),
        .REF_INTERVAL(RI)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .m0_req     (req[0]),
        .m0_we      (we[0]),
        .m0_addr    (addr[0]),
        .m0_wdata   (wdata[0]),
        .m0_sel     (sel[0]),
        .m0_ack     (ack0),
        .m0_rdata   (rdata0),
        .m1_req     (req[1]),
        .m1_we      (we[1]),
        .m1_addr    (addr[1]),
        .m1_wdata   (wdata[1]),
        .m1_sel     (sel[1]),
        .m1_ack     (ack1),
        .m1_rdata   (rdata1),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .c_we       (c_we),
        .c_addr     (c_addr),
        .c_wdata    (c_wdata),
        .c_sel      (c_sel),
        .c_rvalid   (c_rvalid),
        .c_rdata    (c_rdata),
        .c_ref_req  (c_ref_req),
        .c_ref_ack  (c_ref_ack),
        .ref_overrun(ref_overrun),
        .grant      (grant)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ackFor(input int k);
        return (mPhase == P_ACK) && (mWho == k);
    endfunction

    task automatic modelReset();
        mPhase    = P_IDLE;
        mCyc      = 0;
        mPend     = 0;
        mOver     = 0;
        mWho      = 0;
        mFav      = 0;
        mWe       = 1'b0;
        mAddr     = '0;
        mWdata    = '0;
        mSel      = '0;
        mRd[0]    = '0;
        mRd[1]    = '0;
        lastAcked = -1;
    endtask

    // Advance the model across one rising edge using the current drives.
    task automatic modelAdvance();
        bit expire, clr, oldPend;
        int pick;
        if (rst) begin
            modelReset();
            return;
        end
        expire  = ((mCyc % RI) == RI - 1);
        clr     = (mPhase == P_REFRESH) && c_ref_ack;
        oldPend = mPend;
        mCyc++;
        mOver = expire && oldPend && !clr;
        if (expire) mPend = 1;
        else if (clr) mPend = 0;
        case (mPhase)
            P_IDLE: begin
                if (oldPend) begin
                    mPhase = P_REFRESH;
                end else if (req[0] || req[1]) begin
                    if (req[0] && req[1]) pick = mFav;
                    else pick = req[1] ? 1 : 0;
                    mWho   = pick;
                    mWe    = we[pick];
                    mAddr  = addr[pick];
                    mWdata = wdata[pick];
                    mSel   = sel[pick];
                    mPhase = P_ISSUE;
                end
            end
            P_ISSUE:   if (c_ready) mPhase = mWe ? P_ACK : P_WAIT_RD;
            P_WAIT_RD: if (c_rvalid) begin mRd[mWho] = c_rdata; mPhase = P_ACK; end
            P_ACK: begin
                mFav   = 1 - mWho;
                mPhase = P_IDLE;
            end
            default:   if (c_ref_ack) mPhase = P_IDLE;
        endcase
    endtask

    task automatic tick();
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic sampleAll();
        checkOutput("c_valid",     32'(c_valid),     32'(mPhase == P_ISSUE));
        checkOutput("c_ref_req",   32'(c_ref_req),   32'(mPhase == P_REFRESH));
        checkOutput("m0_ack",      32'(ack0),        32'(ackFor(0)));
        checkOutput("m1_ack",      32'(ack1),        32'(ackFor(1)));
        checkOutput("m0_rdata",    rdata0,           mRd[0]);
        checkOutput("m1_rdata",    rdata1,           mRd[1]);
        checkOutput("c_we",        32'(c_we),        32'(mWe));
        checkOutput("c_addr",      32'(c_addr),      32'(mAddr));
        checkOutput("c_wdata",     c_wdata,          mWdata);
        checkOutput("c_sel",       32'(c_sel),       32'(mSel));
        checkOutput("grant",       32'(grant),       32'(mWho));
        checkOutput("ref_overrun", 32'(ref_overrun), 32'(mOver));
        if (altCheck && mPhase == P_ACK) begin
            if (lastAcked >= 0) checkOutput("alternate", 32'(grant), 32'(1 - lastAcked));
            lastAcked = mWho;
        end
    endtask

    // Randomized masters and controller, reacting to the model's view.
    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            if (ackFor(k)) req[k] = 1'b0;
            if (!req[k] && $urandom_range(99) < reqPct) begin
                req[k]   = 1'b1;
                we[k]    = ($urandom_range(99) < wePct);
                addr[k]  = AW'($urandom);
                wdata[k] = $urandom;
                sel[k]   = 4'($urandom);
            end
        end
        c_ready   = ($urandom_range(99) < readyPct);
        c_rvalid  = (mPhase == P_WAIT_RD) ? ($urandom_range(99) < rvalidPct) : ($urandom_range(9) == 0);
        c_rdata   = $urandom;
        c_ref_ack = (mPhase == P_REFRESH) && ($urandom_range(99) < refAckPct);
    endtask

    task automatic runRandom(input int n, input int rq, input int wp, input int rp,
                             input int vp, input int ap, input bit alt);
        reqPct = rq; wePct = wp; readyPct = rp; rvalidPct = vp; refAckPct = ap;
        altCheck = alt;
        lastAcked = -1;
        for (int i = 0; i < n; i++) begin
            sampleAll();
            applyStimulus();
            tick();
        end
        altCheck = 0;
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;
        altCheck = 0;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0; sel[k] = '0;
        end
        c_ready = 1'b0; c_rvalid = 1'b0; c_rdata = '0; c_ref_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        modelReset();
        rst = 1'b0;

        // m0 write with the controller always ready.
        sampleAll();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h000010; wdata[0] = 32'hDEADBEEF; sel[0] = 4'hF;
        c_ready = 1'b1;
        tick();
        checkOutput("t1_c_valid", 32'(c_valid), 32'd1);
        checkOutput("t1_c_wdata", c_wdata, 32'hDEADBEEF);
        checkOutput("t1_c_addr", 32'(c_addr), 32'h10);
        sampleAll();
        tick();
        checkOutput("t1_m0_ack", 32'(ack0), 32'd1);
        sampleAll();
        req[0] = 1'b0;
        tick();
        sampleAll();
        c_ready = 1'b0;
        tick();

        // m1 read: accepted two cycles late, data three cycles after accept.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 23'h000020; wdata[1] = '0; sel[1] = 4'hF;
        sampleAll();
        tick();
        sampleAll(); tick();
        sampleAll(); tick();
        sampleAll(); c_ready = 1'b1; tick();
        c_ready = 1'b0;
        sampleAll(); tick();
        sampleAll(); tick();
        sampleAll(); c_rvalid = 1'b1; c_rdata = 32'h12345678; tick();
        c_rvalid = 1'b0; c_rdata = 32'h0BADF00D;
        checkOutput("t2_m1_ack", 32'(ack1), 32'd1);
        checkOutput("t2_m1_rdata", rdata1, 32'h12345678);
        checkOutput("t2_m0_rdata", rdata0, 32'h0);
        sampleAll();
        req[1] = 1'b0;
        tick();
        sampleAll(); tick();
        checkOutput("t2_m1_rdata_held", rdata1, 32'h12345678);

        // Both masters writing back to back: grants must alternate.
        runRandom(400, 100, 100, 100, 50, 50, 1);
        // General mixed traffic with slow reads so refresh lands mid-read.
        runRandom(2000, 40, 40, 60, 15, 30, 0);
        // Refresh ack withheld across several intervals, then released.
        runRandom(4 * RI, 50, 50, 70, 30, 0, 0);
        runRandom(200, 50, 50, 70, 30, 100, 0);

        // Reset in the middle of a read, then a late read-data strobe.
        reqPct = 60; wePct = 0; readyPct = 80; rvalidPct = 5; refAckPct = 50;
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            sampleAll();
            if (mPhase == P_WAIT_RD) begin
                found = 1;
            end else begin
                applyStimulus();
                tick();
            end
        end
        checkOutput("reach_wait_rd", 32'(found), 32'd1);
        if (found) begin
            c_rvalid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            checkOutput("rst_c_valid", 32'(c_valid), 32'd0);
            checkOutput("rst_m0_ack", 32'(ack0), 32'd0);
            checkOutput("rst_m1_ack", 32'(ack1), 32'd0);
            sampleAll();
            c_rvalid = 1'b1;
            c_rdata  = $urandom;
            tick();
            c_rvalid = 1'b0;
        end
        runRandom(400, 50, 50, 70, 30, 50, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
